play_audio: RTL and testbench
=============================

Name: play_audio

Overview:
- Read-side counterpart of the audio capture path.
- On request, reads DEPTH sample words out of the shared sample RAM, one at a time, and presents each on a valid/ready stream. Downstream consumers are the FFT/magnitude stage or a debug/DAC sink.
- Signals completion with a one-cycle done pulse, mirroring the capture block's do/did handshake with the top module.

Parameters:
- DATA_W, 10, sample word width (matches RAM data width)
- ADDR_W, 11, RAM address width
- DEPTH, 1024, number of words read per request; power of two, 2 <= DEPTH <= 2**(ADDR_W-1)

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- do_play_audio  in  1  request level from top module; sampled only in IDLE
- did_play_audio  out  1  one-cycle pulse when all DEPTH words have been accepted downstream
- busy  out  1  high in every state except IDLE
- mem_rd_en  out  1  RAM read strobe, one cycle per word
- mem_addr  out  ADDR_W  RAM read address
- mem_data  in  DATA_W  RAM read data, valid the cycle after mem_rd_en/mem_addr are sampled (synchronous RAM, 1-cycle latency)
- out_data  out  DATA_W  stream sample
- out_valid  out  1  stream valid
- out_ready  in  1  stream ready from consumer
- out_last  out  1  high with out_valid on word index DEPTH-1

Behaviour:
- Reset (async, rst=1) sets: state=IDLE, index=0, mem_rd_en=0, mem_addr=0, out_data=0, out_valid=0, out_last=0, did_play_audio=0, busy=0. Reset mid-transfer discards the transfer; no done pulse is issued.
- All outputs are registered. index is a log2(DEPTH)+1-bit counter.
- State machine:
  - IDLE: did_play_audio<=0. If do_play_audio=1, then index<=0 and go to ISSUE.
  - ISSUE: mem_addr<=addr(index), mem_rd_en<=1, go to WAIT.
  - WAIT: mem_rd_en<=0, go to CAPTURE.
  - CAPTURE: out_data<=mem_data, out_valid<=1, out_last<=(index==DEPTH-1), go to HOLD.
  - HOLD: hold out_data, out_valid and out_last stable until out_ready=1. The transfer completes on the edge where out_valid=1 and out_ready=1; on that edge out_valid<=0 and out_last<=0. Then, if index==DEPTH-1 go to DONE; otherwise index<=index+1 and go to ISSUE.
  - DONE: did_play_audio<=1 for exactly one cycle, go to IDLE.
- Timing:
  - With out_ready tied high: 4 cycles per word (ISSUE, WAIT, CAPTURE, HOLD), so 4*DEPTH+2 cycles from request to done pulse.
  - First out_valid rises 3 cycles after the IDLE edge that samples do_play_audio=1.
- Boundary conditions:
  - out_ready high while out_valid is low has no effect.
  - out_ready low holds HOLD indefinitely; no further RAM reads are issued.
  - do_play_audio is ignored outside IDLE. If it is still high when DONE returns to IDLE, a new transfer starts on the next cycle. This is level behaviour, identical to the capture block.
  - mem_addr retains its last value when not reading. Upper address bits beyond log2(DEPTH) are zero.
  - Exactly one outstanding RAM read at any time; never two mem_rd_en pulses without an intervening handshake.

Optional Feature:
- Macro: PLAY_AUDIO_BITREV_EN
- Defined: addr(index) is the bit-reversal of index[log2(DEPTH)-1:0], zero-extended to ADDR_W. Example for DEPTH=1024: index 1 maps to address 512, index 2 to 256. This reads a bit-reversed-stored buffer back in natural order.
- Undefined: addr(index) = index, zero-extended (linear read).
- No other behaviour changes.

Test Plan:
- Reset: assert rst mid-HOLD at word 5 -> all outputs 0 immediately (async), state IDLE, no did_play_audio pulse; release rst with do_play_audio=0 -> stays idle, busy=0.
- Linear read, out_ready=1, RAM preloaded with data[a]=a%1024, DEPTH=1024 -> 1024 beats with out_data=0,1,...,1023; out_last only on beat 1023; did_play_audio pulses once at cycle 4098 after request.
- PLAY_AUDIO_BITREV_EN defined, same RAM -> mem_addr sequence 0,512,256,768,...; out_data equals those addresses; 1024 beats total.
- Backpressure: out_ready low for 7 cycles on beat 3 -> out_data/out_valid stable for all 7 cycles, no mem_rd_en during stall, beat 4 address issued the cycle after the handshake.
- Request held high continuously -> back-to-back transfers; exactly one did_play_audio pulse per 1024 beats; index restarts at 0.
- do_play_audio toggled during transfer -> ignored; transfer count unchanged; busy stays high until the DONE cycle.

Source files
------------

// File: rtl/play_audio.sv
// play_audio: reads DEPTH words out of the shared sample RAM on request and
// streams them over a valid/ready port, then pulses did_play_audio once.
// Optional feature macro: PLAY_AUDIO_BITREV_EN (bit-reversed read addressing).
//
// state   | meaning
// IDLE    | waiting for do_play_audio
// ISSUE   | drive RAM address and read strobe for the current index
// WAIT    | RAM access latency cycle
// CAPTURE | latch RAM data onto the stream
// HOLD    | present sample until the consumer accepts it
// DONE    | pulse did_play_audio, return to IDLE
module play_audio #(
    parameter int DATA_W = 10,
    parameter int ADDR_W = 11,
    parameter int DEPTH  = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              do_play_audio,
    output logic              did_play_audio,
    output logic              busy,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_data,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last
);

    localparam int IDX_LSB_W = $clog2(DEPTH);
    localparam int IDX_W     = IDX_LSB_W + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_CAPTURE,
        S_HOLD,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    index_q, index_d;
    logic                mem_rd_en_q, mem_rd_en_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   out_data_q, out_data_d;
    logic                out_valid_q, out_valid_d;
    logic                out_last_q, out_last_d;
    logic                did_q, did_d;
    logic                busy_q, busy_d;
    logic [IDX_LSB_W-1:0] idx_low;
    logic [ADDR_W-1:0]   rd_addr;

    // Map the word index onto a RAM address; upper address bits stay zero.
    always_comb begin
        idx_low = index_q[IDX_LSB_W-1:0];
`ifdef PLAY_AUDIO_BITREV_EN
        rd_addr = '0;
        for (int i = 0; i < IDX_LSB_W; i++) begin
            rd_addr[i] = idx_low[IDX_LSB_W-1-i];
        end
`else
        rd_addr = ADDR_W'(idx_low);
`endif
    end

    // Next-state and registered-output logic for the read sequencer.
    always_comb begin
        state_d     = state_q;
        index_d     = index_q;
        mem_rd_en_d = mem_rd_en_q;
        mem_addr_d  = mem_addr_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        did_d       = did_q;
        case (state_q)
            S_IDLE: begin
                did_d = 1'b0;
                if (do_play_audio) begin
                    index_d = '0;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                mem_addr_d  = rd_addr;
                mem_rd_en_d = 1'b1;
                state_d     = S_WAIT;
            end
            S_WAIT: begin
                mem_rd_en_d = 1'b0;
                state_d     = S_CAPTURE;
            end
            S_CAPTURE: begin
                out_data_d  = mem_data;
                out_valid_d = 1'b1;
                out_last_d  = (index_q == LAST_IDX);
                state_d     = S_HOLD;
            end
            S_HOLD: begin
                if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                    out_last_d  = 1'b0;
                    if (index_q == LAST_IDX) begin
                        state_d = S_DONE;
                    end else begin
                        index_d = index_q + IDX_W'(1);
                        state_d = S_ISSUE;
                    end
                end
            end
            S_DONE: begin
                did_d   = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // State and output registers; reset drops everything back to idle at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            index_q     <= '0;
            mem_rd_en_q <= 1'b0;
            mem_addr_q  <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            did_q       <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            index_q     <= index_d;
            mem_rd_en_q <= mem_rd_en_d;
            mem_addr_q  <= mem_addr_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            did_q       <= did_d;
            busy_q      <= busy_d;
        end
    end

    assign did_play_audio = did_q;
    assign busy           = busy_q;
    assign mem_rd_en      = mem_rd_en_q;
    assign mem_addr       = mem_addr_q;
    assign out_data       = out_data_q;
    assign out_valid      = out_valid_q;
    assign out_last       = out_last_q;

endmodule

// File: tb/tb_play_audio.sv
// tb_play_audio: scenario table plus hand-written reset sequence for play_audio.
// Expected stream contents come from the RAM image and the addressing rule
// (linear, or bit-reversed when PLAY_AUDIO_BITREV_EN is defined).
module tb_play_audio;

    localparam int DATA_W   = 10;
    localparam int ADDR_W   = 11;
    localparam int DEPTH    = 1024;
    localparam int LOG2     = $clog2(DEPTH);
    localparam int XFER_CYC = 4 * DEPTH + 2;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              do_play_audio = 1'b0;
    logic              did_play_audio;
    logic              busy;
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data = '0;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic              out_last;

    play_audio #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .do_play_audio  (do_play_audio),
        .did_play_audio (did_play_audio),
        .busy           (busy),
        .mem_rd_en      (mem_rd_en),
        .mem_addr       (mem_addr),
        .mem_data       (mem_data),
        .out_data       (out_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_last       (out_last)
    );

    always #5 clk = ~clk;

    // Synchronous sample RAM, one cycle read latency.
    logic [DATA_W-1:0] ram [0:2**ADDR_W-1];
    always @(posedge clk) if (mem_rd_en) mem_data <= ram[mem_addr];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;
    int cur_vec = -1;

    // Monitor bookkeeping, written only from the main test process.
    int beat_cnt = 0, beat_base = 0, rd_cnt = 0, rd_base = 0;
    int did_cnt = 0, did_cyc = 0, stall_cnt = 0, neg_cnt = 0, last_hs_neg = 0;
    bit outstanding = 0, prev_stall = 0, prev_did = 0, mon_en = 0;
    logic [DATA_W-1:0] prev_data = '0;
    logic prev_last = 1'b0;

    // Ready generator controls, written by the main process.
    int rmode = 0, st_beat = 0, st_len = 0;
    int st_used = 0;

    typedef struct {
        int mode;       // 0 ready high, 1 stall at a beat, 2 random ready
        int stl_beat;
        int stl_len;
        bit rand_data;
        bit toggle_req;
        int n_xfer;     // transfers run with do_play_audio held
        int exp_beats;
        int exp_dones;
        int exp_stalls; // -1: not fixed
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s vec=%0d actual=%0d required=%0d", name, cur_vec, act, exp);
        end
    endtask

    // Address of word k of a transfer, by plain arithmetic.
    function automatic logic [ADDR_W-1:0] exp_addr(input int k);
        int v, r;
        v = k % DEPTH;
        r = v;
`ifdef PLAY_AUDIO_BITREV_EN
        r = 0;
        for (int i = 0; i < LOG2; i++) begin
            r = r * 2 + (v % 2);
            v = v / 2;
        end
`endif
        return ADDR_W'(r);
    endfunction

    // Shape out_ready just after each rising edge.
    always @(posedge clk) begin
        #1;
        case (rmode)
            1: begin
                if (out_valid && (beat_cnt - beat_base) == st_beat) begin
                    if (st_used < st_len) begin
                        out_ready = 1'b0;
                        st_used++;
                    end else begin
                        out_ready = 1'b1;
                    end
                end else begin
                    st_used = 0;
                    out_ready = 1'b1;
                end
            end
            2: out_ready = ($urandom_range(0, 3) != 0);
            default: out_ready = 1'b1;
        endcase
    end

    // Advance to the next falling edge and check the stream/RAM protocol.
    task automatic tick();
        int r, b;
        @(negedge clk);
        neg_cnt++;
        if (rst) begin
            outstanding = 0;
            prev_stall  = 0;
            prev_did    = 0;
            return;
        end
        if (!mon_en) return;
        if (prev_stall) begin
            check("stall_valid", out_valid, 1);
            check("stall_data", out_data, prev_data);
            check("stall_last", out_last, prev_last);
            check("stall_no_rd", mem_rd_en, 0);
        end
        if (mem_rd_en) begin
            r = (rd_cnt - rd_base) % DEPTH;
            check("rd_addr", mem_addr, exp_addr(r));
            check("rd_single", outstanding, 0);
            if (r != 0) check("rd_after_hs", neg_cnt - last_hs_neg, 2);
            outstanding = 1;
            rd_cnt++;
        end
        if (!out_valid) check("last_without_valid", out_last, 0);
        if (out_valid && out_ready) begin
            b = (beat_cnt - beat_base) % DEPTH;
            check("beat_data", out_data, ram[exp_addr(b)]);
            check("beat_last", out_last, (b == DEPTH - 1));
            beat_cnt++;
            outstanding = 0;
            last_hs_neg = neg_cnt;
        end else if (out_valid) begin
            stall_cnt++;
        end
        prev_stall = out_valid && !out_ready;
        prev_data  = out_data;
        prev_last  = out_last;
        if (did_play_audio) begin
            check("did_one_cycle", prev_did, 0);
            did_cnt++;
            did_cyc = cyc;
        end
        prev_did = did_play_audio;
    endtask

    task automatic fill_ram(input bit rnd);
        for (int a = 0; a < 2**ADDR_W; a++)
            ram[a] = rnd ? DATA_W'($urandom) : DATA_W'(a % DEPTH);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_did"}, did_play_audio, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_rd_en"}, mem_rd_en, 0);
        check({tag, "_addr"}, mem_addr, 0);
        check({tag, "_data"}, out_data, 0);
        check({tag, "_valid"}, out_valid, 0);
        check({tag, "_last"}, out_last, 0);
    endtask

    task automatic run_vec(input vec_t v);
        int b0, d0, s0, start, first_valid, lim;
        fill_ram(v.rand_data);
        rmode = v.mode;
        st_beat = v.stl_beat;
        st_len = v.stl_len;
        beat_base = beat_cnt;
        rd_base = rd_cnt;
        b0 = beat_cnt;
        d0 = did_cnt;
        s0 = stall_cnt;
        mon_en = 1;
        tick();
        do_play_audio = 1'b1;
        start = cyc;
        first_valid = -1;
        lim = v.n_xfer * XFER_CYC * 4 + 100;
        for (int n = 0; n < lim && (did_cnt - d0) < v.n_xfer; n++) begin
            tick();
            if (first_valid < 0 && out_valid) first_valid = cyc - start;
            if (did_play_audio) check("busy_low_after_done", busy, 0);
            else check("busy_high", busy, 1);
            if (v.toggle_req)
                do_play_audio = ((beat_cnt - b0) < DEPTH - 4) ? 1'($urandom_range(0, 1)) : 1'b0;
            else
                do_play_audio = ((did_cnt - d0) < v.n_xfer - 1) ||
                                (did_play_audio && (did_cnt - d0) < v.n_xfer);
        end
        do_play_audio = 1'b0;
        check("done_seen", did_cnt - d0, v.n_xfer);
        check("first_valid_latency", first_valid, 4);
        check("done_latency", did_cyc - start, v.n_xfer * XFER_CYC + (stall_cnt - s0));
        for (int n = 0; n < 4; n++) tick();
        check("done_count", did_cnt - d0, v.exp_dones);
        check("beat_count", beat_cnt - b0, v.exp_beats);
        check("idle_busy", busy, 0);
        check("idle_valid", out_valid, 0);
        if (v.exp_stalls >= 0) check("stall_cycles", stall_cnt - s0, v.exp_stalls);
        rmode = 0;
    endtask

    initial begin
        int b0, d0;
        //           mode beat      len rnd tog n  beats      dones stalls
        vecs[0] = '{0,   0,        0,  0,  0,  1, DEPTH,     1,    0};
        vecs[1] = '{1,   3,        7,  1,  0,  1, DEPTH,     1,    7};
        vecs[2] = '{2,   0,        0,  1,  0,  1, DEPTH,     1,    -1};
        vecs[3] = '{0,   0,        0,  1,  1,  1, DEPTH,     1,    0};
        vecs[4] = '{0,   0,        0,  1,  0,  2, 2 * DEPTH, 2,    0};
        vecs[5] = '{1,   DEPTH-1,  3,  1,  0,  1, DEPTH,     1,    3};

        #1 rst = 1'b1;
        #1 check_all_zero("reset");
        tick();
        tick();
        rst = 1'b0;
        for (int n = 0; n < 3; n++) tick();
        check_all_zero("idle_after_reset");

        // Reset in the middle of a stalled beat 5.
        cur_vec = 100;
        fill_ram(1'b0);
        rmode = 1;
        st_beat = 5;
        st_len = 100000;
        beat_base = beat_cnt;
        rd_base = rd_cnt;
        b0 = beat_cnt;
        d0 = did_cnt;
        mon_en = 1;
        tick();
        do_play_audio = 1'b1;
        tick();
        do_play_audio = 1'b0;
        for (int n = 0; n < 300 && !((beat_cnt - b0) == 5 && out_valid && !out_ready); n++) tick();
        check("reached_stall_beat5", beat_cnt - b0, 5);
        check("stalled_valid", out_valid, 1);
        tick();
        tick();
        #2 rst = 1'b1;
        #1 check_all_zero("async_reset");
        mon_en = 0;
        rmode = 0;
        for (int n = 0; n < 3; n++) tick();
        rst = 1'b0;
        for (int n = 0; n < 6; n++) begin
            tick();
            check("post_reset_busy", busy, 0);
            check("post_reset_did", did_play_audio, 0);
            check("post_reset_rd", mem_rd_en, 0);
            check("post_reset_valid", out_valid, 0);
        end
        check("no_done_after_abort", did_cnt - d0, 0);

        for (int i = 0; i < 6; i++) begin
            cur_vec = i;
            run_vec(vecs[i]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
